dmem_wait_responder: RTL and testbench

- Data-memory responder on the memory side of the core's load/store port, with a valid/ready request and response handshake.
- Accepts one request at a time, waits a programmable number of cycles to model memory wait states, then returns load data or commits store data.
- Decodes access size and signedness from the 3-bit RW_type field using RISC-V func3 encoding.
- Stands in for the single-cycle data memory when the pipeline is run against slow memory.

---
 rtl/dmem_wait_responder.sv | 139 +++++++++++++
 tb/tb_dmem_wait_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_responder.sv
// Single-outstanding data-memory responder: one request at a time, resp_valid LAT cycles after acceptance.
// Response is held stable until resp_ready; no new request is accepted until the response is consumed.
module dmem_wait_responder #(
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_rw_type,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        run;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  type_q;
  logic [31:0] mem [DEPTH];

  logic        accept, enter_resp;
  logic        e_we;
  logic [31:0] e_addr, e_wdata;
  logic [2:0]  e_type;
  logic        is_b, is_h, is_w, bad_type, err;
  logic [IDX_W-1:0] idx;
  logic [31:0] word, word_sh, ld_data, st_data;
  logic [15:0] half_sel;
  logic [3:0]  be;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LAT == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && run;
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign accept     = req_valid && req_ready;
  assign enter_resp = ((state == IDLE) && accept && (LAT == 1)) ||
                      ((state == WAIT) && (cnt == 4'd1));

  // With LAT=1 the response is formed on the acceptance edge, so decode the live inputs in IDLE
  always_comb begin
    e_we    = (state == IDLE) ? req_we      : we_q;
    e_addr  = (state == IDLE) ? req_addr    : addr_q;
    e_type  = (state == IDLE) ? req_rw_type : type_q;
    e_wdata = (state == IDLE) ? req_wdata   : wdata_q;
  end

  always_comb begin
    is_b     = (e_type[1:0] == 2'b00);
    is_h     = (e_type[1:0] == 2'b01);
    is_w     = (e_type == 3'b010);
    bad_type = (e_type[1:0] == 2'b11) || (e_type == 3'b110) || (e_type[2] && e_we);
    err      = bad_type || (is_h && e_addr[0]) || (is_w && (e_addr[1:0] != 2'b00)) ||
               (e_addr[31:2] >= 30'(DEPTH));
    idx      = e_addr[IDX_W+1:2];
    word     = mem[idx];
    word_sh  = word >> {e_addr[1:0], 3'b000};
    half_sel = e_addr[1] ? word[31:16] : word[15:0];
    if (is_b)      ld_data = {{24{word_sh[7] & ~e_type[2]}}, word_sh[7:0]};
    else if (is_h) ld_data = {{16{half_sel[15] & ~e_type[2]}}, half_sel};
    else           ld_data = word;
    if (is_b)      be = 4'b0001 << e_addr[1:0];
    else if (is_h) be = e_addr[1] ? 4'b1100 : 4'b0011;
    else           be = 4'b1111;
    if (is_b)      st_data = {4{e_wdata[7:0]}};
    else if (is_h) st_data = {2{e_wdata[15:0]}};
    else           st_data = e_wdata;
  end

  always_ff @(posedge clk) begin
    if (enter_resp && e_we && !err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      type_q     <= 3'd0;
      wdata_q    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        type_q  <= req_rw_type;
        wdata_q <= req_wdata;
        cnt     <= 4'(LAT - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        resp_rdata <= (err || e_we) ? 32'd0 : ld_data;
        resp_err   <= err;
      end else if ((state == RESP) && resp_ready) begin
        resp_rdata <= 32'd0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench: main instance at LAT=2, second instance at LAT=1 for back-to-back streaming.
module tb_dmem_wait_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_rw_type;
  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [2:0]  b_req_rw_type;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_wait_responder #(.DEPTH(256), .LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_rw_type(req_rw_type), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));

  dmem_wait_responder #(.DEPTH(256), .LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_rw_type(b_req_rw_type), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err));

  // One full transaction on the main instance; lat counts edges after the acceptance edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] typ,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_rw_type = typ; req_wdata = wd;
    resp_ready = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL accept_timeout addr=%h", addr); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata; er = resp_err;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_rw_type = '0;
    req_wdata = '0; resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_rw_type = '0;
    b_req_wdata = '0; b_resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin
      errors++; $display("FAIL reset_resp got v=%b e=%b d=%h exp 0", resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if ({er, rd} !== 33'd0) begin errors++; $display("FAIL sw_resp got e=%b d=%h exp e=0 d=0", er, rd); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL sw_latency got %0d edges exp 1", lat); end
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    checks++;
    if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL lw_resp got e=%b d=%h exp e=0 d=deadbeef", er, rd);
    end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL lw_latency got %0d edges exp 1", lat); end
  endtask

  task automatic test_byte_half;
    logic [31:0] rd; logic er; int lat;
    logic        we [7];
    logic [31:0] ad [7];
    logic [2:0]  ty [7];
    logic [31:0] wd [7];
    logic [31:0] ex [7];
    we[0]=1; ad[0]=32'h11; ty[0]=3'b000; wd[0]=32'hFFFFFF7F; ex[0]=32'h00000000;
    we[1]=0; ad[1]=32'h11; ty[1]=3'b000; wd[1]=32'h0;        ex[1]=32'h0000007F;
    we[2]=0; ad[2]=32'h13; ty[2]=3'b100; wd[2]=32'h0;        ex[2]=32'h000000DE;
    we[3]=0; ad[3]=32'h12; ty[3]=3'b001; wd[3]=32'h0;        ex[3]=32'hFFFFDEAD;
    we[4]=0; ad[4]=32'h12; ty[4]=3'b101; wd[4]=32'h0;        ex[4]=32'h0000DEAD;
    we[5]=0; ad[5]=32'h10; ty[5]=3'b000; wd[5]=32'h0;        ex[5]=32'hFFFFFFEF;
    we[6]=0; ad[6]=32'h10; ty[6]=3'b010; wd[6]=32'h0;        ex[6]=32'hDEAD7FEF;
    for (int i = 0; i < 7; i++) begin
      do_req(we[i], ad[i], ty[i], wd[i], rd, er, lat);
      checks++;
      if ({er, rd} !== {1'b0, ex[i]}) begin
        errors++; $display("FAIL byte_half[%0d] got e=%b d=%h exp e=0 d=%h", i, er, rd, ex[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    logic        we [7];
    logic [31:0] ad [7];
    logic [2:0]  ty [7];
    we[0]=0; ad[0]=32'h12;  ty[0]=3'b010;
    we[1]=0; ad[1]=32'h13;  ty[1]=3'b001;
    we[2]=0; ad[2]=32'h10;  ty[2]=3'b011;
    we[3]=0; ad[3]=32'h400; ty[3]=3'b010;
    we[4]=1; ad[4]=32'h13;  ty[4]=3'b001;
    we[5]=1; ad[5]=32'h10;  ty[5]=3'b100;
    we[6]=0; ad[6]=32'h10;  ty[6]=3'b110;
    for (int i = 0; i < 7; i++) begin
      do_req(we[i], ad[i], ty[i], 32'h55555555, rd, er, lat);
      checks++;
      if ({er, rd} !== {1'b1, 32'h0}) begin
        errors++; $display("FAIL err[%0d] got e=%b d=%h exp e=1 d=0", i, er, rd);
      end
    end
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    checks++;
    if ({er, rd} !== {1'b0, 32'hDEAD7FEF}) begin
      errors++; $display("FAIL err_unchanged got e=%b d=%h exp e=0 d=dead7fef", er, rd);
    end
    do_req(1'b1, 32'h3FC, 3'b010, 32'hCAFEF00D, rd, er, lat);
    do_req(1'b0, 32'h3FC, 3'b010, 32'h0, rd, er, lat);
    checks++;
    if ({er, rd} !== {1'b0, 32'hCAFEF00D}) begin
      errors++; $display("FAIL last_word got e=%b d=%h exp e=0 d=cafef00d", er, rd);
    end
  endtask

  task automatic test_hold;
    logic [31:0] rd; logic er; int lat; int n; int bad;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_rw_type = 3'b010; resp_ready = 1'b0;
    @(posedge clk); #1;
    // a store presented while busy must be ignored
    req_we = 1'b1; req_wdata = 32'h0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD7FEF || req_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_stable got %0d bad cycles exp 0 (v=%b d=%h rdy=%b)", bad, resp_valid, resp_rdata, req_ready);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_release got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready);
    end
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    checks++;
    if ({er, rd} !== {1'b0, 32'hDEAD7FEF}) begin
      errors++; $display("FAIL busy_ignored got e=%b d=%h exp e=0 d=dead7fef", er, rd);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat; int seen;
    do_req(1'b1, 32'h20, 3'b010, 32'h0BADCAFE, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_rw_type = 3'b010;
    req_wdata = 32'h12345678; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid} !== 2'b00) begin
      errors++; $display("FAIL mid_reset got rdy=%b v=%b exp 0 0", req_ready, resp_valid);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (resp_valid === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL resp_after_reset got %0d exp 0", seen); end
    resp_ready = 1'b0;
    do_req(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
    checks++;
    if ({er, rd} !== {1'b0, 32'h0BADCAFE}) begin
      errors++; $display("FAIL store_dropped got e=%b d=%h exp e=0 d=0badcafe", er, rd);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_rw_type = 3'b010;
    req_wdata = 32'h11112222; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1) begin errors++; $display("FAIL persist_resp got %b exp 1", resp_valid); end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_req(1'b0, 32'h24, 3'b010, 32'h0, rd, er, lat);
    checks++;
    if ({er, rd} !== {1'b0, 32'h11112222}) begin
      errors++; $display("FAIL store_persist got e=%b d=%h exp e=0 d=11112222", er, rd);
    end
  endtask

  task automatic test_back_to_back;
    logic        we [8];
    logic [31:0] ad [8];
    logic [2:0]  ty [8];
    logic [31:0] wd [8];
    logic [31:0] ex [8];
    logic [31:0] got [8];
    int acc_cyc [8];
    int acc, nresp;
    logic gerr;
    we[0]=1; ad[0]=32'h0; ty[0]=3'b010; wd[0]=32'h11223344; ex[0]=32'h0;
    we[1]=1; ad[1]=32'h4; ty[1]=3'b010; wd[1]=32'h55667788; ex[1]=32'h0;
    we[2]=1; ad[2]=32'h5; ty[2]=3'b000; wd[2]=32'h00000099; ex[2]=32'h0;
    we[3]=0; ad[3]=32'h2; ty[3]=3'b001; wd[3]=32'h0;        ex[3]=32'h00001122;
    we[4]=0; ad[4]=32'h4; ty[4]=3'b010; wd[4]=32'h0;        ex[4]=32'h55669988;
    we[5]=0; ad[5]=32'h0; ty[5]=3'b100; wd[5]=32'h0;        ex[5]=32'h00000044;
    we[6]=0; ad[6]=32'h5; ty[6]=3'b000; wd[6]=32'h0;        ex[6]=32'hFFFFFF99;
    we[7]=0; ad[7]=32'h0; ty[7]=3'b010; wd[7]=32'h0;        ex[7]=32'h11223344;
    for (int i = 0; i < 8; i++) begin got[i] = 32'hX; acc_cyc[i] = 0; end
    acc = 0; nresp = 0; gerr = 1'b0;
    @(negedge clk);
    b_resp_ready = 1'b1; b_req_valid = 1'b1;
    b_req_we = we[0]; b_req_addr = ad[0]; b_req_rw_type = ty[0]; b_req_wdata = wd[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (b_resp_valid === 1'b1) begin
        if (nresp < 8) got[nresp] = b_resp_rdata;
        gerr = gerr | b_resp_err;
        nresp++;
      end
      if (b_req_valid && b_req_ready === 1'b1) begin
        acc_cyc[acc] = cyc;
        acc++;
        @(posedge clk); #1;
        if (acc < 8) begin
          b_req_we = we[acc]; b_req_addr = ad[acc]; b_req_rw_type = ty[acc]; b_req_wdata = wd[acc];
        end else begin
          b_req_valid = 1'b0;
        end
      end else begin
        @(posedge clk); #1;
      end
      @(negedge clk);
    end
    b_resp_ready = 1'b0;
    checks++;
    if (acc != 8 || nresp != 8) begin
      errors++; $display("FAIL b2b_counts got acc=%0d resp=%0d exp 8 8", acc, nresp);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (acc_cyc[i+1] - acc_cyc[i] != 2) begin
        errors++; $display("FAIL b2b_gap[%0d] got %0d exp 2", i, acc_cyc[i+1] - acc_cyc[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== ex[i]) begin
        errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, got[i], ex[i]);
      end
    end
    checks++;
    if (gerr !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", gerr); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte_half;
    test_errors;
    test_hold;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
